// File: rtl/fifo_rd_stream.sv
// Read-side master for a show-ahead FIFO: pops words into a 2-entry buffer and
// presents them as a valid/ready stream framed into fixed-length packets.
module fifo_rd_stream #(
    parameter int WIDTH   = 16,
    parameter int PKT_LEN = 4,
    parameter int CW      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_fifo_rdata,
    input  logic             i_fifo_empty,
    output logic             o_fifo_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    input  logic             i_ready,
    output logic [CW-1:0]    o_pkt_cnt
);

    localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic [BW-1:0]    r_beat;
    logic [CW-1:0]    r_pkt_cnt;

    logic w_pop;
    logic w_hs;
    logic w_beat_last;

    // Pop depends only on registered occupancy and FIFO/flush/reset flags, never on i_ready.
    assign w_pop       = !i_rst && !i_fifo_empty && !i_flush && (r_count != 2'd2);
    assign w_hs        = o_valid && i_ready;
    assign w_beat_last = (r_beat == LAST_BEAT);

    assign o_fifo_pop = w_pop;
    assign o_valid    = (r_count != 2'd0);
    assign o_data     = r_head;
    assign o_last     = o_valid && w_beat_last;
    assign o_pkt_cnt  = r_pkt_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= 2'd0;
            r_beat    <= '0;
            r_pkt_cnt <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
            r_beat  <= '0;
        end else begin
            if (w_hs && (r_count == 2'd2)) begin
                r_head <= r_tail;
            end
            // Incoming word lands in head when head is free or retiring this cycle.
            if (w_pop) begin
                if ((r_count == 2'd0) || ((r_count == 2'd1) && w_hs)) begin
                    r_head <= i_fifo_rdata;
                end else begin
                    r_tail <= i_fifo_rdata;
                end
            end
            case ({w_pop, w_hs})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_hs) begin
                if (w_beat_last) begin
                    r_beat    <= '0;
                    r_pkt_cnt <= r_pkt_cnt + CW'(1);
                end else begin
                    r_beat <= r_beat + BW'(1);
                end
            end
        end
    end

endmodule
